// File: rtl/audio_pkg.sv
// Shared audio types for the effects chain: sample width and the stereo pair payload.
package audio_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] l;
      logic signed [SAMPLE_W-1:0] r;
   } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master timing: BCLK divider, bit index k within the frame and LRCLK.
// fall_c marks the clk where BCLK falls; frame_start_c marks the fall where k wraps to 0.
module i2s_clk_gen #(
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned BCLK_DIV = 4,
   parameter int unsigned K_W      = $clog2(2 * SLOT_W)
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic           bclk,
   output logic           lrclk,
   output logic           fall_c,
   output logic           frame_start_c,
   output logic [K_W-1:0] k
);

   localparam int unsigned      CNT_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * SLOT_W - 1);
   localparam logic [K_W-1:0]   K_SLOT   = K_W'(SLOT_W);

   logic [CNT_W-1:0] cnt;
   logic [K_W-1:0]   k_nxt;
   logic             edge_c;

   always_comb begin
      edge_c        = (cnt == CNT_LAST);
      fall_c        = edge_c && bclk;
      frame_start_c = fall_c && (k == K_LAST);
      k_nxt         = (k == K_LAST) ? '0 : k + K_W'(1);
   end

   // Divider toggles BCLK; k and LRCLK move together on the falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         bclk  <= 1'b0;
         lrclk <= 1'b0;
         k     <= '0;
      end else begin
         cnt <= edge_c ? '0 : cnt + CNT_W'(1);
         if (edge_c) bclk <= ~bclk;
         if (fall_c) begin
            k     <= k_nxt;
            lrclk <= (k_nxt >= K_SLOT);
         end
      end
   end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S (Philips) master transmitter: one-entry holding buffer, frame register, underrun flag.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_transmitter
   import audio_pkg::*;
#(
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [SAMPLE_W-1:0] left_in,
   input  logic signed [SAMPLE_W-1:0] right_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       i2s_bclk,
   output logic                       i2s_lrclk,
   output logic                       i2s_sdata,
   output logic                       underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                underrun_cnt
`endif
);

   localparam int unsigned    FRAME_W = 2 * SLOT_W;
   localparam int unsigned    K_W     = $clog2(FRAME_W);
   localparam logic [K_W-1:0] K_LAST  = K_W'(FRAME_W - 1);

   stereo_sample_t     hold_q;
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_c;
   logic [K_W-1:0]     k;
   logic               fall_c;
   logic               commit_c;
   logic               accept_c;
   logic               armed_q;

   i2s_clk_gen #(
      .SLOT_W   (SLOT_W),
      .BCLK_DIV (BCLK_DIV),
      .K_W      (K_W)
   ) u_clk_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .bclk          (i2s_bclk),
      .lrclk         (i2s_lrclk),
      .fall_c        (fall_c),
      .frame_start_c (commit_c),
      .k             (k)
   );

   assign accept_c = in_valid && in_ready;

   // Next frame word: left/right left-justified in their slots, mute when the buffer is empty.
   always_comb begin
      frame_c = '0;
      if (!in_ready) begin
         frame_c[FRAME_W-1 -: SAMPLE_W] = hold_q.l;
         frame_c[SLOT_W-1  -: SAMPLE_W] = hold_q.r;
      end
   end

   // At index k the pin carries frame bit FRAME_W-1-k of the word about to be indexed,
   // which yields the one-bit delay and puts F[0] at k=0 of the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         in_ready  <= 1'b1;
         frame_q   <= '0;
         i2s_sdata <= 1'b0;
         underrun  <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         underrun <= commit_c && in_ready && armed_q;
         if (accept_c) armed_q <= 1'b1;
         if (fall_c) i2s_sdata <= frame_q[K_LAST - k];
         if (commit_c) frame_q <= frame_c;
         if (accept_c) begin
            hold_q.l <= left_in;
            hold_q.r <= right_in;
            in_ready <= 1'b0;
         end else if (commit_c) begin
            in_ready <= 1'b1;
         end
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: default build (32-bit slots, BCLK_DIV=4) plus a
// second instance with 16-bit slots and BCLK_DIV=2. Frames are rebuilt from the pins.
module tb_i2s_transmitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] left0, right0, left1, right1;
   logic        in_valid0, in_valid1;
   logic        in_ready0, bclk0, lrclk0, sdata0, underrun0;
   logic        in_ready1, bclk1, lrclk1, sdata1, underrun1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] ucnt0, ucnt1;
`endif

   int total = 0;
   int bad   = 0;

   i2s_transmitter u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .left_in   (left0),
      .right_in  (right0),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .i2s_bclk  (bclk0),
      .i2s_lrclk (lrclk0),
      .i2s_sdata (sdata0),
      .underrun  (underrun0)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (ucnt0)
`endif
   );

   i2s_transmitter #(.SLOT_W(16), .BCLK_DIV(2)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .left_in   (left1),
      .right_in  (right1),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .i2s_bclk  (bclk1),
      .i2s_lrclk (lrclk1),
      .i2s_sdata (sdata1),
      .underrun  (underrun1)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (ucnt1)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] word32(input logic [15:0] l, input logic [15:0] r);
      return {l, 16'h0000, r, 16'h0000};
   endfunction

   // Receiver model for the default instance: k tracked from BCLK falls, data taken on rises.
   int          k0, nb0, lr_bad0, ur_wide0;
   logic [63:0] sh0;
   logic        pb0, pu0;
   logic [63:0] rxq0[$];
   int          urf0[$];
   initial begin lr_bad0 = 0; ur_wide0 = 0; end

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k0 = 0; nb0 = 0; sh0 = '0; pb0 = 1'b0; pu0 = 1'b0;
      end else begin
         if (pb0 && !bclk0) k0 = (k0 == 63) ? 0 : k0 + 1;
         if (!pb0 && bclk0) begin
            if (lrclk0 !== (k0 >= 32)) lr_bad0++;
            sh0 = {sh0[62:0], sdata0};
            nb0++;
            if (k0 == 0) begin
               if (nb0 == 64) rxq0.push_back(sh0);
               nb0 = 0;
            end
         end
         if (underrun0) begin
            if (pu0) ur_wide0++;
            else urf0.push_back(rxq0.size() + 1);
         end
         pu0 = underrun0;
         pb0 = bclk0;
      end
   end

   // Receiver model for the 16-bit-slot instance, also measuring BCLK and LRCLK periods.
   int          cyc = 0;
   int          k1, nb1, lr_bad1, lastb1, lastf1, bper1, fper1;
   logic [31:0] sh1;
   logic        pb1, pl1, pu1;
   logic [31:0] rxq1[$];
   int          urf1[$];
   initial begin lr_bad1 = 0; bper1 = 0; fper1 = 0; end
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k1 = 0; nb1 = 0; sh1 = '0; pb1 = 1'b0; pl1 = 1'b0; pu1 = 1'b0;
         lastb1 = -1; lastf1 = -1;
      end else begin
         if (pb1 && !bclk1) k1 = (k1 == 31) ? 0 : k1 + 1;
         if (!pb1 && bclk1) begin
            if (lastb1 >= 0) bper1 = cyc - lastb1;
            lastb1 = cyc;
            if (lrclk1 !== (k1 >= 16)) lr_bad1++;
            sh1 = {sh1[30:0], sdata1};
            nb1++;
            if (k1 == 0) begin
               if (nb1 == 32) rxq1.push_back(sh1);
               nb1 = 0;
            end
         end
         if (!pl1 && lrclk1) begin
            if (lastf1 >= 0) fper1 = cyc - lastf1;
            lastf1 = cyc;
         end
         if (underrun1 && !pu1) urf1.push_back(rxq1.size() + 1);
         pu1 = underrun1;
         pl1 = lrclk1;
         pb1 = bclk1;
      end
   end

   function automatic logic [63:0] fr0(input int i);
      return (i < rxq0.size()) ? rxq0[i] : 64'hx;
   endfunction

   function automatic logic [63:0] fr1(input int i);
      return (i < rxq1.size()) ? {32'h0, rxq1[i]} : 64'hx;
   endfunction

   task automatic send0(input logic [15:0] l, input logic [15:0] r, input string tag);
      int n = 0;
      while (!in_ready0 && n < 3000) begin tick(); n++; end
      check({tag, "_ready"}, in_ready0, 1);
      left0 = l; right0 = r; in_valid0 = 1'b1;
      tick();
      in_valid0 = 1'b0;
      check({tag, "_taken"}, in_ready0, 0);
   endtask

   task automatic wait_frames0(input int n, input string tag);
      int t = 0;
      while (rxq0.size() < n && t < 4000) begin tick(); t++; end
      check(tag, rxq0.size() >= n, 1);
   endtask

   task automatic wait_ur0(input int n, input string tag);
      int t = 0;
      while (urf0.size() < n && t < 4000) begin tick(); t++; end
      check(tag, urf0.size() >= n, 1);
   endtask

   logic [15:0] hl[3] = '{16'h1234, 16'h0F0F, 16'hFFFF};
   logic [15:0] hr[3] = '{16'hFEDC, 16'hF0F0, 16'h0001};

   initial begin
      int t;
      int p0;
      rst_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
      left0 = '0; right0 = '0; left1 = '0; right1 = '0;
      repeat (2) tick();
      check("rst_ready", in_ready0, 1);
      check("rst_bclk", bclk0, 0);
      check("rst_lrclk", lrclk0, 0);
      check("rst_sdata", sdata0, 0);
      check("rst_underrun", underrun0, 0);
      rst_n = 1'b1;

      // Short-slot instance gets one pair right away and then runs dry.
      left1 = 16'hA5A5; right1 = 16'h5A5A; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      check("s16_taken", in_ready1, 0);

      // Single pair, then starve: next frame is mute and flags underrun.
      send0(16'h8001, 16'h7FFE, "pair1");
      wait_ur0(1, "ur1_wait");
      check("ur1_frame", urf0[0], 2);

      // Hold in_valid across three pairs; each is taken only right after a commit.
      in_valid0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         left0 = hl[i]; right0 = hr[i];
         t = 0;
         while (!in_ready0 && t < 3000) begin tick(); t++; end
         check("hold_ready", in_ready0, 1);
         if (i > 0) check("hold_at_commit", k0, 0);
         tick();
         check("hold_taken", in_ready0, 0);
      end
      in_valid0 = 1'b0;
      wait_ur0(2, "ur2_wait");
      check("ur2_frame", urf0[1], 6);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("ucnt_after_first", ucnt0 != 16'd0, 1);
`endif

      // Offer a pair on the very commit clk with the buffer empty.
      t = 0;
      while (!(k0 == 63 && bclk0) && t < 3000) begin tick(); t++; end
      check("commit_find", k0, 63);
      repeat (3) tick();
      check("commit_pre_ready", in_ready0, 1);
      left0 = 16'h4321; right0 = 16'h8000; in_valid0 = 1'b1;
      tick();
      in_valid0 = 1'b0;
      check("commit_taken", in_ready0, 0);
      check("commit_ur_cnt", urf0.size(), 3);
      check("commit_ur_frame", urf0[2], 7);

      wait_ur0(4, "ur4_wait");
      check("ur4_frame", urf0[3], 9);
      send0(16'h5555, 16'hAAAA, "pairE");
      send0(16'h1111, 16'h2222, "pairG");
      t = 0;
      while (!(rxq0.size() >= 10 && k0 == 20) && t < 3000) begin tick(); t++; end
      check("mid_frame_k", k0, 20);
      repeat (4) tick();
      check("mid_bclk_high", bclk0, 1);
      check("mid_buffer_full", in_ready0, 0);

      check("frame0_mute", fr0(0), 64'h0);
      check("frame1_pair", fr0(1), word32(16'h8001, 16'h7FFE));
      check("frame2_mute", fr0(2), 64'h0);
      for (int i = 0; i < 3; i++) check("frame_hold", fr0(3 + i), word32(hl[i], hr[i]));
      check("frame6_mute", fr0(6), 64'h0);
      check("frame7_mute", fr0(7), 64'h0);
      check("frame8_pair", fr0(8), word32(16'h4321, 16'h8000));
      check("frame9_mute", fr0(9), 64'h0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("ucnt_four", ucnt0, 4);
`endif

      check("s16_frame0", fr1(0), 64'h0);
      check("s16_frame1", fr1(1), 64'hA5A5_5A5A);
      check("s16_frame2", fr1(2), 64'h0);
      check("s16_bclk_per", bper1, 4);
      check("s16_frame_per", fper1, 128);
      check("s16_ur_frame", (urf1.size() > 0) ? urf1[0] : -1, 2);
      check("s16_lrclk", lr_bad1, 0);

      // Reset in the middle of frame 10: everything drops at once, no clock edge needed.
      rst_n = 1'b0;
      #1;
      check("arst_bclk", bclk0, 0);
      check("arst_lrclk", lrclk0, 0);
      check("arst_sdata", sdata0, 0);
      check("arst_ready", in_ready0, 1);
      check("arst_underrun", underrun0, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("arst_ucnt", ucnt0, 0);
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      p0 = rxq0.size();
      check("arst_no_partial", p0, 10);
      repeat (3) tick();
      check("first_rise_early", bclk0, 0);
      tick();
      check("first_rise", bclk0, 1);
      wait_frames0(p0 + 2, "post_rst_frames");
      check("post_rst_f0", fr0(p0), 64'h0);
      check("post_rst_f1", fr0(p0 + 1), 64'h0);
      check("post_rst_no_ur", urf0.size(), 4);
      check("lrclk_align", lr_bad0, 0);
      check("ur_one_clk", ur_wide0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
